// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared types for the sized data memory (dmem_sized) and its alignment helper.
//   size_e       : RISC-V load/store funct3 encodings carried on req_size
//   state_e      : controller states (CLEAR wipes the array, RUN serves requests)
//   size_legal() : whether a funct3 value is a legal access for a load or store

package dmem_pkg;

    typedef enum logic [2:0] {
        SIZE_B  = 3'b000,
        SIZE_H  = 3'b001,
        SIZE_W  = 3'b010,
        SIZE_BU = 3'b100,
        SIZE_HU = 3'b101
    } size_e;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Unsigned variants only make sense for loads, so a store using BU/HU
    // is treated the same as an undefined funct3 value.
    function automatic logic size_legal(input logic [2:0] size, input logic we);
        logic ok;
        case (size)
            SIZE_B, SIZE_H, SIZE_W: ok = 1'b1;
            SIZE_BU, SIZE_HU:       ok = ~we;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_sized_if.sv
// dmem_sized_if
// Request/response bundle between a load/store unit and dmem_sized.
//   req_valid/req_ready : request handshake, accepted when both are high
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address (ADDR_W bits)
//   req_size            : funct3 access size
//   req_wdata           : right-aligned store data
//   rsp_valid           : one-cycle pulse, one per accepted request
//   rsp_rdata           : extended load data (0 for stores and faults)
//   rsp_err             : access fault for the responded request
// Modports: master drives requests, slave (the memory) drives ready/responses.

interface dmem_sized_if #(
    parameter int ADDR_W = 32
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_size;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_align.sv
// dmem_align
// Purely combinational lane steering for dmem_sized.
//   addr_lo       : byte offset within the word (req_addr[1:0])
//   size          : funct3 access size
//   wdata         : right-aligned store data
//   rword         : current contents of the addressed word
//   byte_en       : lanes a store of this size/offset touches
//   wdata_shifted : store data moved onto its lanes
//   load_data     : selected byte/half/word, sign- or zero-extended
//   misalign      : access is misaligned and must fault
// Build option DMEM_MISALIGN_TRAP_EN: when defined, misaligned H/HU/W raise
// misalign; otherwise the offset is silently rounded down to natural alignment.

module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_shifted,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [1:0]  eff_off;
    logic [31:0] rshift;

    // Decide the effective byte offset; the misalignment policy is a build choice.
    always_comb begin
        misalign = 1'b0;
        eff_off  = addr_lo;
        case (size)
            SIZE_H, SIZE_HU: begin
`ifdef DMEM_MISALIGN_TRAP_EN
                misalign = addr_lo[0];
`else
                eff_off  = {addr_lo[1], 1'b0};
`endif
            end
            SIZE_W: begin
`ifdef DMEM_MISALIGN_TRAP_EN
                misalign = (addr_lo != 2'b00);
`else
                eff_off  = 2'b00;
`endif
            end
            default: ;
        endcase
    end

    // Store side: lane mask and data moved up to the addressed lanes.
    always_comb begin
        byte_en = 4'b0000;
        case (size)
            SIZE_B, SIZE_BU: byte_en = 4'b0001 << eff_off;
            SIZE_H, SIZE_HU: byte_en = 4'b0011 << eff_off;
            SIZE_W:          byte_en = 4'b1111;
            default:         byte_en = 4'b0000;
        endcase
        wdata_shifted = wdata << {eff_off, 3'b000};
    end

    // Load side: bring the addressed lanes down to bit 0, then extend.
    always_comb begin
        rshift    = rword >> {eff_off, 3'b000};
        load_data = 32'h0;
        case (size)
            SIZE_B:  load_data = {{24{rshift[7]}}, rshift[7:0]};
            SIZE_BU: load_data = {24'h0, rshift[7:0]};
            SIZE_H:  load_data = {{16{rshift[15]}}, rshift[15:0]};
            SIZE_HU: load_data = {16'h0, rshift[15:0]};
            SIZE_W:  load_data = rshift;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_sized.sv
// dmem_sized
// Byte/half/word addressable data memory with a self-clearing start-up.
// After reset the array is zeroed one word per cycle (CLEAR, DEPTH cycles),
// then requests are accepted one per cycle (RUN) and answered with a single
// rsp_valid pulse exactly one cycle after acceptance.
//   clk   : clock, everything on the rising edge
//   reset : synchronous, active-high; restarts the full clear
//   bus   : dmem_sized_if slave modport (request/response signals)
// Parameters: DEPTH (words, power of two >= 4), ADDR_W (byte-address width).
// Build option DMEM_MISALIGN_TRAP_EN: misaligned H/HU/W accesses fault instead
// of being rounded down to natural alignment.

module dmem_sized
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    dmem_sized_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] BYTE_LIMIT = (ADDR_W + 1)'(DEPTH * 4);

    state_e            state;
    state_e            next_state;
    logic [IDX_W-1:0]  clear_idx;
    logic [IDX_W-1:0]  next_idx;

    logic [31:0]       mem [DEPTH];

    logic [IDX_W-1:0]  word_idx;
    logic [31:0]       rword;
    logic [3:0]        byte_en;
    logic [31:0]       wdata_shifted;
    logic [31:0]       load_data;
    logic              misalign;
    logic              addr_oob;
    logic              size_bad;
    logic              fault;
    logic              accept;
    logic              do_write;

    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rsp_rdata_q;

    // Request decode. An out-of-range address still indexes some word; the
    // fault flag makes sure that word is neither written nor returned.
    assign word_idx = bus.req_addr[IDX_W+1:2];
    assign rword    = mem[word_idx];
    assign addr_oob = ({1'b0, bus.req_addr} >= BYTE_LIMIT);
    assign size_bad = ~size_legal(bus.req_size, bus.req_we);
    assign fault    = addr_oob | size_bad | misalign;
    assign accept   = bus.req_valid & (state == RUN);
    assign do_write = accept & bus.req_we & ~fault;

    dmem_align u_align (
        .addr_lo       (bus.req_addr[1:0]),
        .size          (bus.req_size),
        .wdata         (bus.req_wdata),
        .rword         (rword),
        .byte_en       (byte_en),
        .wdata_shifted (wdata_shifted),
        .load_data     (load_data),
        .misalign      (misalign)
    );

    // State register and clear pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            clear_idx <= '0;
        end else begin
            state     <= next_state;
            clear_idx <= next_idx;
        end
    end

    // CLEAR walks the pointer through every word once and then hands over to
    // RUN on the cycle that zeroes the last word.
    always_comb begin
        next_state = state;
        next_idx   = clear_idx;
        case (state)
            CLEAR: begin
                next_idx = clear_idx + 1'b1;
                if (clear_idx == IDX_W'(DEPTH - 1)) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                next_idx = '0;
            end
            default: begin
                next_state = CLEAR;
                next_idx   = '0;
            end
        endcase
    end

    // Storage array. No write happens during reset; the clear sequence that
    // follows reset takes care of wiping the contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clear_idx] <= 32'h0;
            end else if (do_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (byte_en[i]) begin
                        mem[word_idx][8*i +: 8] <= wdata_shifted[8*i +: 8];
                    end
                end
            end
        end
    end

    // Response register. Load data is sampled from the array at the accepting
    // edge, so a store on the previous edge is already visible to it. Data and
    // error are forced to zero whenever no response is being presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept & fault;
            rsp_rdata_q <= (accept && !fault && !bus.req_we) ? load_data : 32'h0;
        end
    end

    assign bus.req_ready = (state == RUN);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/dmem_sized.md
DMEM_SIZED -- requirements
Module: dmem_sized

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning memory depth in 32-bit words (power of two, at least 4).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: request present.
REQ-006 SHALL have port req_ready, output, 1 bit: request accepted this cycle when high with req_valid.
REQ-007 SHALL have port req_we, input, 1 bit: 1 means store, 0 means load.
REQ-008 SHALL have port req_addr, input, ADDR_W bits: byte address.
REQ-009 SHALL have port req_size, input, 3 bits: RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-010 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port rsp_valid, output, 1 bit: one-cycle response pulse.
REQ-012 SHALL have port rsp_rdata, output, 32 bits: load result, extended per req_size.
REQ-013 SHALL have port rsp_err, output, 1 bit: access fault for the responded request.

Function
REQ-014 SHALL implement FSM states CLEAR and RUN; req_ready = 1 only in RUN.
REQ-015 SHALL, in CLEAR, write zero to one word per cycle at index 0..DEPTH-1, then enter RUN; CLEAR lasts exactly DEPTH cycles.
REQ-016 SHALL accept one request per cycle in RUN (back-to-back allowed) and assert rsp_valid exactly 1 cycle after acceptance, with one response per accepted request.
REQ-017 SHALL commit a store at the accepting edge, writing only the addressed byte lanes (B: addr[1:0] lane; H: lanes addr[1]*2 and +1; W: all four lanes).
REQ-018 SHALL, for loads, return the selected byte or half, sign-extended for B/H and zero-extended for BU/HU, or the full word for W.
REQ-019 SHALL return new data for a load accepted the cycle after a store to the same word.
REQ-020 SHALL, for stores, drive rsp_rdata = 0.
REQ-021 SHALL set rsp_err = 1, suppress any write and drive rsp_rdata = 0 when req_addr >= DEPTH*4, or when req_size is illegal (011, 110, 111; or 100/101 with req_we = 1).
REQ-022 SHALL hold rsp_rdata and rsp_err at 0 whenever rsp_valid = 0.

Reset
REQ-023 SHALL, while reset is high, enter CLEAR with the clear index at 0 and drive req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-024 SHALL, when reset is asserted mid-CLEAR or mid-RUN, drop any pending response and restart the full clear from index 0.

Configuration
REQ-025 SHALL provide macro DMEM_MISALIGN_TRAP_EN.
REQ-026 SHALL, with DMEM_MISALIGN_TRAP_EN defined, treat a misaligned H/HU (addr[0] = 1) or W (addr[1:0] != 0) access as a fault: rsp_err = 1, no write, rsp_rdata = 0.
REQ-027 SHALL, without DMEM_MISALIGN_TRAP_EN, force low address bits to natural alignment (H: addr[0] = 0; W: addr[1:0] = 0), with no error.

Structure
REQ-028 SHALL place in package dmem_pkg the req_size encodings (enum) and the FSM state enum.
REQ-029 SHALL have one combinational sub-module, dmem_align, that computes byte-enable, shifted write data and extended load data.
REQ-030 SHALL store memory as DEPTH x 32-bit words with per-byte write enables.

Verification
REQ-031 SHALL check reset for 1 cycle then release: req_ready = 0 for exactly 256 cycles, then 1; LW 0x000 -> 0x00000000.
REQ-032 SHALL check SW 0x004 = 0xA5A5A5A5, then SB 0x005 = 0x3C, then LW 0x004 -> 0xA5A53CA5; LB 0x005 -> 0x0000003C; LBU 0x007 -> 0x000000A5; LB 0x007 -> 0xFFFFFFA5.
REQ-033 SHALL check SH 0x012 = 0x8001, then LH 0x012 -> 0xFFFF8001 and LHU 0x012 -> 0x00008001, issued back-to-back, with rsp_valid high on 2 consecutive cycles.
REQ-034 SHALL check SW 0x400 = 0xDEADBEEF (out of range) -> rsp_err = 1; LW 0x3FC -> 0x00000000; illegal size 011 -> rsp_err = 1.
REQ-035 SHALL check LW 0x006 after REQ-032: with DMEM_MISALIGN_TRAP_EN -> rsp_err = 1 and rsp_rdata = 0; without it -> 0xA5A53CA5 and rsp_err = 0.
REQ-036 SHALL check reset asserted 1 cycle after SW 0x010 = 0x12345678 is accepted: no rsp_valid, a full 256-cycle clear, then LW 0x010 -> 0x00000000.
